apb_cmd_master: RTL

APB requester that drives the peripheral side of the coefficient/control bus toward the coefficient RAM and control-register responder. Software or a sequencer pushes read/write commands into a small command FIFO. The block issues each command as a standard two-phase APB transfer (SETUP, then ACCESS) and waits on PREADY. Each completed or timed-out transfer returns exactly one response pulse.

---
 rtl/apb_cmd_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: command FIFO feeding a two-phase APB requester with PREADY
// timeout; one response pulse per command, in command order.
`default_nettype none

module apb_cmd_master #(
    parameter int ADDR_WIDTH  = 7,
    parameter int PDATA_WIDTH = 32,
    parameter int COMP        = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 16,
    localparam int SEL_W      = (COMP > 1) ? $clog2(COMP) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [SEL_W-1:0]       cmd_sel,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [PDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_write,
    output logic [PDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [COMP-1:0]        PSELx,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDR_WIDTH-1:0]  PADDR,
    output logic [PDATA_WIDTH-1:0] PWDATA,
    input  logic                   PREADY,
    input  logic [PDATA_WIDTH-1:0] PRDATA
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    logic                   mem_write [FIFO_DEPTH];
    logic [SEL_W-1:0]       mem_sel   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  mem_addr  [FIFO_DEPTH];
    logic [PDATA_WIDTH-1:0] mem_wdata [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_write[wr_ptr] <= cmd_write;
            mem_sel[wr_ptr]   <= cmd_sel;
            mem_addr[wr_ptr]  <= cmd_addr;
            mem_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- APB sequencer ----------------
    state_t                 state, state_nxt;
    logic [TO_W-1:0]        to_cnt, to_nxt;
    logic [COMP-1:0]        psel_nxt;
    logic                   penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]  paddr_nxt;
    logic [PDATA_WIDTH-1:0] pwdata_nxt;
    logic                   rsp_valid_nxt, rsp_write_nxt, rsp_err_nxt;
    logic [PDATA_WIDTH-1:0] rsp_rdata_nxt;
    logic                   load, done;

    always_comb begin
        state_nxt     = state;
        to_nxt        = to_cnt;
        psel_nxt      = PSELx;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        rsp_valid_nxt = 1'b0;
        rsp_write_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
        load          = 1'b0;
        done          = 1'b0;
        pop           = 1'b0;

        case (state)
            S_IDLE: begin
                if (!empty) load = 1'b1;
            end
            S_SETUP: begin
                penable_nxt = 1'b1;
                to_nxt      = '0;
                state_nxt   = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    done          = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = PWRITE;
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    done          = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = PWRITE;
                    rsp_err_nxt   = 1'b1;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
                if (done) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt   = S_IDLE;
                        psel_nxt    = '0;
                        penable_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Head-of-FIFO launch is shared by IDLE and back-to-back completion
        if (load) begin
            pop         = 1'b1;
            state_nxt   = S_SETUP;
            penable_nxt = 1'b0;
            psel_nxt    = COMP'(1) << mem_sel[rd_ptr];
            pwrite_nxt  = mem_write[rd_ptr];
            paddr_nxt   = mem_addr[rd_ptr];
            pwdata_nxt  = mem_write[rd_ptr] ? mem_wdata[rd_ptr] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            to_cnt    <= '0;
            PSELx     <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            to_cnt    <= to_nxt;
            PSELx     <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_write <= rsp_write_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

    assign busy = !empty || (state != S_IDLE);

endmodule

`default_nettype wire
